// File: rtl/result_ascii_tx.sv
// Formats a captured ALU opcode/result as an ASCII frame ("op=HH" plus optional CR LF) for a byte-wide UART.
// One byte per tx_start/tx_done handshake; tx_start follows a sampled start or tx_done by one cycle.
module result_ascii_tx #(
    parameter int unsigned APPEND_CRLF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic [7:0] result,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

    localparam logic [2:0] LAST_IDX = (APPEND_CRLF != 0) ? 3'd5 : 3'd3;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [7:0] r_op;
    logic [7:0] r_res;
    logic       r_tx_start;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [7:0] w_sym;
    logic [7:0] w_byte;

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02: op_known = 1'b1;
            default:                                               op_known = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    always_comb begin
        w_sym = 8'h3F;
        case (r_op)
            8'h20:   w_sym = 8'h2B;
            8'h22:   w_sym = 8'h2D;
            8'h24:   w_sym = 8'h41;
            8'h25:   w_sym = 8'h4F;
            8'h26:   w_sym = 8'h58;
            8'h27:   w_sym = 8'h4E;
            8'h03:   w_sym = 8'h3E;
            8'h02:   w_sym = 8'h2F;
            default: w_sym = 8'h3F;
        endcase
    end

    // Frame bytes come only from the captured operands, so input changes mid-frame are invisible.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = w_sym;
            3'd1:    w_byte = 8'h3D;
            3'd2:    w_byte = hex_ascii(r_res[7:4]);
            3'd3:    w_byte = hex_ascii(r_res[3:0]);
            3'd4:    w_byte = 8'h0D;
            3'd5:    w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_op       <= 8'h00;
            r_res      <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op       <= opcode;
                        r_res      <= result;
                        r_err      <= ~op_known(opcode);
                        r_idx      <= 3'd0;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: r_state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_tx_start <= 1'b1;
                            r_state    <= SEND;
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data is gated to zero in IDLE so the bus is quiet whenever no frame is active.
    assign tx_data  = r_busy ? w_byte : 8'h00;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Directed bench: instance a appends CR/LF, instance b does not; a tx_done responder replays each byte.
module tb_result_ascii_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b, tx_done;
    logic [7:0] opcode, result;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_start_a, tx_start_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    bit         sel;
    logic [7:0] obs_tx_data;
    logic       obs_tx_start, obs_busy, obs_done, obs_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] got [0:7];
    int first_cyc, done_cyc, td_cyc, gap_bad, n_err_hi, n_err_lo;

    always #5 clk = ~clk;

    result_ascii_tx #(.APPEND_CRLF(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .opcode(opcode), .result(result),
        .tx_done(tx_done), .tx_data(tx_data_a), .tx_start(tx_start_a), .busy(busy_a),
        .done(done_a), .err(err_a));

    result_ascii_tx #(.APPEND_CRLF(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .opcode(opcode), .result(result),
        .tx_done(tx_done), .tx_data(tx_data_b), .tx_start(tx_start_b), .busy(busy_b),
        .done(done_b), .err(err_b));

    assign obs_tx_data  = sel ? tx_data_b  : tx_data_a;
    assign obs_tx_start = sel ? tx_start_b : tx_start_a;
    assign obs_busy     = sel ? busy_b     : busy_a;
    assign obs_done     = sel ? done_b     : done_a;
    assign obs_err      = sel ? err_b      : err_a;

    task automatic do_start(input logic [7:0] op, input logic [7:0] res, input bit with_td);
        @(negedge clk);
        opcode = op;
        result = res;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tx_done = with_td;
    endtask

    // inj_kind 1: start + new operands in first WAIT cycle of byte inj_idx; 2: tx_done during SEND of byte inj_idx.
    task automatic collect(input int dly, input int stop_at, input int inj_idx, input int inj_kind,
                           output int cnt, output int ndone, output bit stable, output bit tmo);
        int wctr, post;
        bit pending, seen_done;
        logic [7:0] held;
        cnt = 0; ndone = 0; stable = 1; tmo = 1; pending = 0; seen_done = 0; post = 0; wctr = 0; held = 8'h00;
        first_cyc = -1; done_cyc = -1; td_cyc = -100; gap_bad = 0; n_err_hi = 0; n_err_lo = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; tx_done = 1'b0;
            if (obs_busy) begin
                if (obs_err) n_err_hi++; else n_err_lo++;
            end
            if (obs_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                seen_done = 1;
            end
            if (obs_tx_start) begin
                if (cnt < 8) got[cnt] = obs_tx_data;
                if (first_cyc < 0) first_cyc = cyc;
                else if (cyc != td_cyc + 1) gap_bad++;
                held = obs_tx_data; pending = 1; wctr = dly;
                if (cnt == inj_idx && inj_kind == 2) tx_done = 1'b1;
                cnt++;
            end else if (pending) begin
                if (obs_tx_data !== held) stable = 0;
                if (cnt - 1 == stop_at) begin
                    tmo = 0;
                    break;
                end
                if (cnt - 1 == inj_idx && inj_kind == 1 && wctr == dly) begin
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                    opcode = 8'h27; result = 8'hFF;
                end
                wctr--;
                if (wctr == 0) begin
                    tx_done = 1'b1; td_cyc = cyc; pending = 0;
                end
            end
            if (seen_done) begin
                post++;
                if (post > 6) begin
                    tmo = 0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start_a = 0; start_b = 0; tx_done = 0; opcode = 8'h20; result = 8'h5A; sel = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_start_a, busy_a, done_a, err_a, tx_data_a} !== 12'h000) begin
            errors++; $display("FAIL reset_a got=%h exp=000", {tx_start_a, busy_a, done_a, err_a, tx_data_a});
        end
        checks++;
        if ({tx_start_b, busy_b, done_b, err_b, tx_data_b} !== 12'h000) begin
            errors++; $display("FAIL reset_b got=%h exp=000", {tx_start_b, busy_b, done_b, err_b, tx_data_b});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_start_a, busy_a, done_a, err_a, tx_data_a} !== 12'h000) begin
            errors++; $display("FAIL idle_after_reset got=%h exp=000", {tx_start_a, busy_a, done_a, err_a, tx_data_a});
        end
    endtask

    task automatic test_frame_crlf;
        logic [7:0] exp [0:5];
        int cnt, nd; bit st, tmo;
        exp = '{8'h2B, 8'h3D, 8'h35, 8'h41, 8'h0D, 8'h0A};
        sel = 0;
        do_start(8'h20, 8'h5A, 0);
        collect(3, -1, -1, 0, cnt, nd, st, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL crlf_timeout got=%0d exp=0", tmo); end
        checks++; if (cnt !== 6) begin errors++; $display("FAIL crlf_count got=%0d exp=6", cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL crlf_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL crlf_done_count got=%0d exp=1", nd); end
        checks++; if (first_cyc !== 0) begin errors++; $display("FAIL crlf_start_latency got=%0d exp=0", first_cyc); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL crlf_next_start_latency got=%0d exp=0", gap_bad); end
        checks++; if (done_cyc !== td_cyc + 1) begin errors++; $display("FAIL crlf_done_latency got=%0d exp=%0d", done_cyc, td_cyc + 1); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL crlf_data_stable got=%0d exp=1", st); end
        checks++; if (n_err_hi !== 0) begin errors++; $display("FAIL crlf_err got=%0d exp=0", n_err_hi); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL crlf_busy_end got=%0d exp=0", busy_a); end
    endtask

    task automatic test_frame_nocrlf;
        logic [7:0] exp [0:3];
        int cnt, nd; bit st, tmo;
        exp = '{8'h3E, 8'h3D, 8'h46, 8'h30};
        sel = 1;
        do_start(8'h03, 8'hF0, 0);
        collect(1, -1, -1, 0, cnt, nd, st, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL nocrlf_timeout got=%0d exp=0", tmo); end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL nocrlf_count got=%0d exp=4", cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL nocrlf_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL nocrlf_done_count got=%0d exp=1", nd); end
        checks++; if (done_cyc !== td_cyc + 1) begin errors++; $display("FAIL nocrlf_done_latency got=%0d exp=%0d", done_cyc, td_cyc + 1); end
        sel = 0;
    endtask

    task automatic test_err;
        logic [7:0] exp1 [0:5];
        logic [7:0] exp2 [0:5];
        int cnt, nd; bit st, tmo;
        exp1 = '{8'h3F, 8'h3D, 8'h30, 8'h39, 8'h0D, 8'h0A};
        exp2 = '{8'h41, 8'h3D, 8'h42, 8'h37, 8'h0D, 8'h0A};
        sel = 0;
        do_start(8'h11, 8'h09, 0);
        collect(2, -1, -1, 0, cnt, nd, st, tmo);
        checks++; if (cnt !== 6 || tmo !== 1'b0) begin errors++; $display("FAIL err_count got=%0d exp=6", cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp1[i]) begin errors++; $display("FAIL err_byte%0d got=%h exp=%h", i, got[i], exp1[i]); end
        end
        checks++; if (n_err_lo !== 0 || n_err_hi == 0) begin errors++; $display("FAIL err_through_frame got_lo=%0d exp_lo=0", n_err_lo); end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_latched got=%0d exp=1", err_a); end
        do_start(8'h24, 8'hB7, 0);
        collect(2, -1, -1, 0, cnt, nd, st, tmo);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp2[i]) begin errors++; $display("FAIL err_clr_byte%0d got=%h exp=%h", i, got[i], exp2[i]); end
        end
        checks++; if (n_err_hi !== 0 || err_a !== 1'b0) begin errors++; $display("FAIL err_cleared got=%0d exp=0", n_err_hi); end
    endtask

    task automatic test_start_while_busy;
        logic [7:0] exp [0:5];
        int cnt, nd; bit st, tmo;
        exp = '{8'h2D, 8'h3D, 8'h31, 8'h45, 8'h0D, 8'h0A};
        sel = 0;
        do_start(8'h22, 8'h1E, 0);
        collect(3, -1, 2, 1, cnt, nd, st, tmo);
        checks++; if (cnt !== 6 || tmo !== 1'b0) begin errors++; $display("FAIL busy_count got=%0d exp=6", cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL busy_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (nd !== 1 || busy_a !== 1'b0) begin errors++; $display("FAIL busy_extra_frame got_done=%0d exp=1", nd); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp [0:5];
        int cnt, nd; bit st, tmo;
        exp = '{8'h4F, 8'h3D, 8'h41, 8'h31, 8'h0D, 8'h0A};
        sel = 0;
        do_start(8'h26, 8'h3C, 0);
        collect(3, 3, -1, 0, cnt, nd, st, tmo);
        checks++; if (cnt !== 4 || got[3] !== 8'h43 || got[0] !== 8'h58) begin
            errors++; $display("FAIL rst_pre_bytes got=%0d/%h exp=4/43", cnt, got[3]); end
        reset = 1'b0;
        #1;
        checks++;
        if ({tx_start_a, busy_a, done_a, err_a, tx_data_a} !== 12'h000) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=000", {tx_start_a, busy_a, done_a, err_a, tx_data_a});
        end
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_start_a, busy_a, done_a} !== 3'b000) begin
            errors++; $display("FAIL rst_hold_outputs got=%b exp=000", {tx_start_a, busy_a, done_a});
        end
        tx_done = 1'b0;
        opcode = 8'h25; result = 8'hA1; start_a = 1'b1;
        reset = 1'b1;
        collect(1, -1, -1, 0, cnt, nd, st, tmo);
        checks++; if (cnt !== 6 || nd !== 1 || tmo !== 1'b0) begin errors++; $display("FAIL rst_new_frame got=%0d exp=6", cnt); end
        checks++; if (first_cyc !== 0) begin errors++; $display("FAIL rst_start_latency got=%0d exp=0", first_cyc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rst_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_stray_tx_done;
        logic [7:0] exp [0:5];
        int cnt, nd; bit st, tmo;
        exp = '{8'h2F, 8'h3D, 8'h37, 8'h44, 8'h0D, 8'h0A};
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            checks++;
            if ({tx_start_a, busy_a, done_a} !== 3'b000) begin
                errors++; $display("FAIL stray_idle%0d got=%b exp=000", i, {tx_start_a, busy_a, done_a});
            end
        end
        do_start(8'h02, 8'h7D, 1);
        collect(2, -1, 1, 2, cnt, nd, st, tmo);
        checks++; if (cnt !== 6 || nd !== 1 || tmo !== 1'b0) begin errors++; $display("FAIL stray_count got=%0d exp=6", cnt); end
        checks++; if (first_cyc !== 0) begin errors++; $display("FAIL stray_start_accept got=%0d exp=0", first_cyc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL stray_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_crlf();
        test_frame_nocrlf();
        test_err();
        test_start_while_busy();
        test_reset_mid_frame();
        test_stray_tx_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_ascii_tx.md
RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

Interface
REQ-001 SHALL have parameter APPEND_CRLF, default 1, meaning 1 appends CR (0x0D) and LF (0x0A) to each frame and 0 omits them.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to capture opcode and result and send one frame.
REQ-005 SHALL have port opcode, input, 8, the ALU opcode of the completed operation.
REQ-006 SHALL have port result, input, 8, the ALU result.
REQ-007 SHALL have port tx_done, input, 1, a one-cycle pulse from the UART transmitter when the current byte has been sent.
REQ-008 SHALL have port tx_data, output, 8, the ASCII byte for the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, a one-cycle pulse requesting transmission of tx_data.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse after the last byte is acknowledged.
REQ-012 SHALL have port err, output, 1, latched high when the captured opcode is not in the table; cleared on the next accepted start.

Function
REQ-013 SHALL send the frame in this order: opcode symbol, '=' (0x3D), result high-nibble hex, result low-nibble hex, then CR and LF if APPEND_CRLF=1 (frame length 6, otherwise 4).
REQ-014 SHALL map captured opcode to symbol as follows: 0x20->0x2B '+', 0x22->0x2D '-', 0x24->0x41 'A', 0x25->0x4F 'O', 0x26->0x58 'X', 0x27->0x4E 'N', 0x03->0x3E '>', 0x02->0x2F '/'.
REQ-015 SHALL send 0x3F '?' for any other opcode and set err.
REQ-016 SHALL encode hex digits as uppercase ASCII: nibble 0-9 -> 0x30-0x39, nibble A-F -> 0x41-0x46.
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT, FIN.
REQ-018 SHALL, in IDLE with start=1, capture opcode and result, clear err, reset the byte index to 0, and go to SEND.
REQ-019 SHALL, in SEND, assert tx_start for exactly one cycle with tx_data equal to byte[index], then go to WAIT.
REQ-020 SHALL, in WAIT with tx_done=1, go to FIN if index is the last byte; otherwise increment index and go to SEND.
REQ-021 SHALL, in FIN, pulse done for one cycle and return to IDLE.
REQ-022 SHALL have this latency: start sampled at edge t gives tx_start high in cycle t+1; tx_done sampled at edge u gives the next tx_start in cycle u+1; after the last tx_done, done is high in cycle u+1.
REQ-023 SHALL hold tx_data stable from the tx_start pulse until the matching tx_done is sampled.
REQ-024 SHALL hold busy high in SEND, WAIT and FIN, and low only in IDLE.
REQ-025 SHALL ignore start while busy; the captured operands remain unchanged.
REQ-026 SHALL ignore tx_done outside WAIT, including tx_done coincident with tx_start in SEND.
REQ-027 SHALL, when start and tx_done are both high in IDLE, accept start and ignore tx_done.
REQ-028 SHALL take its symbol and hex bytes only from the captured registers, never from live opcode/result inputs.

Reset
REQ-029 SHALL, while reset=0 (asynchronously), force state IDLE, index 0, tx_start 0, done 0, busy 0, err 0, tx_data 0x00, and captured registers 0x00.
REQ-030 SHALL, on reset mid-frame, abandon the frame with no further tx_start or done, and accept a fresh start on the first edge after reset rises.

Verification
REQ-031 SHALL verify: opcode 0x20, result 0x5A, APPEND_CRLF=1, tx_done 3 cycles after each tx_start -> bytes 0x2B,0x3D,0x35,0x41,0x0D,0x0A, done once, err 0.
REQ-032 SHALL verify: opcode 0x03, result 0xF0, APPEND_CRLF=0 -> bytes 0x3E,0x3D,0x46,0x30, done after the 4th tx_done.
REQ-033 SHALL verify: opcode 0x11, result 0x09 -> first byte 0x3F, err=1 through the frame, err=0 after the next start with opcode 0x24 (first byte 0x41).
REQ-034 SHALL verify: second start and new opcode/result applied during WAIT of byte 2 -> frame bytes unchanged, no extra frame.
REQ-035 SHALL verify: reset low during WAIT of byte 3 -> all outputs 0 immediately, no done; a new start after release sends a full correct frame.
REQ-036 SHALL verify: stray tx_done pulses in IDLE and in SEND -> no index advance, byte sequence unchanged.
